morse_char_encoder: RTL and testbench
=====================================

Name: morse_char_encoder

Overview:
Upstream stage of the Morse link: accepts ASCII characters over a valid/ready handshake and serialises each one as an on/off-keyed Morse waveform on a single line. The output drives the same one-bit morse line that the receiver samples. All timing is in units of UNIT_CYCLES clocks.

Parameters:
UNIT_CYCLES, 1, clocks per Morse time unit (must be >= 1)
CNT_W, 8, width of the unit-cycle down-counter (must hold 7*UNIT_CYCLES-1)

Ports:
i_clk  input  1  single system clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_char  input  8  ASCII character to send
i_valid  input  1  i_char is valid
o_ready  output  1  encoder can accept a character this cycle
o_data_morse  output  1  serial Morse line (1 = key down)
o_busy  output  1  high while any mark or gap of a character is being emitted
o_err  output  1  one-cycle pulse: accepted character unsupported, dropped

Behaviour:
- Reset (async, immediate): state IDLE, o_data_morse=0, o_ready=1, o_busy=0, o_err=0, counters cleared. Reset mid-character aborts it; the line drops low immediately.
- Supported set: A-Z, a-z (folded to upper case), 0-9, space (0x20). Anything else is unsupported.
- Code format: 3-bit length (1..5) plus 5-bit pattern, MSB-first, 1=dash, 0=dot.
- Timing: dot = 1 unit high; dash = 3 units high; gap between elements = 1 unit low; after the last element, 3 units low (char gap, no extra element gap); space = 4 units low (7 total after the preceding char gap).
- Handshake: transfer when i_valid && o_ready at a rising edge. o_ready is registered, high only in IDLE, and drops on the edge after a transfer. i_char is captured at the transfer edge; later changes are ignored.
- States:
  - IDLE: line low. On transfer, select by char class:
    - letter/digit -> MARK; o_data_morse=1 from the transfer edge, so the line is high in the next cycle.
    - space -> GAP_WORD.
    - unsupported -> o_err=1 for exactly one cycle, stay IDLE, o_ready remains 1.
  - MARK: high for 1 or 3 units. Then ELEM_GAP if elements remain, else CHAR_GAP.
  - ELEM_GAP: low for 1 unit, then MARK on the next element.
  - CHAR_GAP: low for 3 units, then IDLE.
  - GAP_WORD: low for 4 units, then IDLE.
- o_busy is 1 in every state except IDLE.
- Back-to-back: with i_valid held high, the next transfer occurs in the first IDLE cycle, so the inter-char gap is exactly 3 units plus the 1 IDLE cycle.
- Counter: loaded with units*UNIT_CYCLES-1 on state entry and decremented each cycle; transition when it reaches 0. No wrap; the load value never exceeds 7*UNIT_CYCLES-1.
- Element index: 3-bit counter, compared against the code length.

Decomposition:
- Package morse_pkg:
  - state enum (IDLE, MARK, ELEM_GAP, CHAR_GAP, GAP_WORD)
  - unit constants DOT_U=1, DASH_U=3, ELEM_GAP_U=1, CHAR_GAP_U=3, WORD_EXTRA_U=4
  - code struct {len[2:0], pat[4:0]}
  - the same package is shared with the receiver.
- Sub-module morse_code_rom: purely combinational lookup. Inputs: 8-bit ASCII. Outputs: code struct, is_space, is_valid.

Test Plan:
- Reset: i_rst=1 for 1 cycle, then 0 -> o_data_morse=0, o_ready=1, o_busy=0, o_err=0.
- 'E' (0x45), UNIT_CYCLES=1, transfer at edge 0 -> line high for 1 cycle, low for 3 cycles; o_ready back to 1 at edge 4.
- 'A' (0x61, lower case), UNIT_CYCLES=2 -> line pattern H2 L2 H6 L6 (clocks); o_busy high for 16 cycles.
- "SOS" streamed with i_valid held high, UNIT_CYCLES=1 -> dot-dot-dot / dash-dash-dash / dot-dot-dot, with exactly 3 low units plus 1 IDLE cycle between characters; 3 transfers total.
- '#' (0x23) -> o_err high for exactly 1 cycle; no line activity; o_ready stays 1. Then 'T' -> line high for 3 cycles.
- Reset mid-dash of 'T', asserted asynchronously between edges -> o_data_morse falls in the same cycle and o_ready=1; the next 'E' is encoded normally.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions for the encoder and receiver: FSM states, unit
// timings and the length/pattern code word.
package morse_pkg;

    localparam int unsigned CODE_LEN_W = 3;
    localparam int unsigned CODE_PAT_W = 5;

    localparam int unsigned DOT_U        = 1;
    localparam int unsigned DASH_U       = 3;
    localparam int unsigned ELEM_GAP_U   = 1;
    localparam int unsigned CHAR_GAP_U   = 3;
    localparam int unsigned WORD_EXTRA_U = 4;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        GAP_WORD
    } morse_state_t;

    // Pattern is left-aligned: the first element sits in pat[CODE_PAT_W-1], 1 = dash.
    typedef struct packed {
        logic [CODE_LEN_W-1:0] len;
        logic [CODE_PAT_W-1:0] pat;
    } morse_code_t;

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII to Morse code lookup; lower case folds to upper case.
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [7:0]  i_char,
    output morse_code_t o_code,
    output logic        o_is_space,
    output logic        o_is_valid
);

    logic [7:0] w_up;

    always_comb begin
        w_up = i_char;
        if (i_char >= 8'h61 && i_char <= 8'h7A) begin
            w_up = i_char - 8'h20;
        end
    end

    always_comb begin
        o_code     = '0;
        o_is_space = 1'b0;
        o_is_valid = 1'b1;
        case (w_up)
            "A": o_code = {3'd2, 5'b01000};
            "B": o_code = {3'd4, 5'b10000};
            "C": o_code = {3'd4, 5'b10100};
            "D": o_code = {3'd3, 5'b10000};
            "E": o_code = {3'd1, 5'b00000};
            "F": o_code = {3'd4, 5'b00100};
            "G": o_code = {3'd3, 5'b11000};
            "H": o_code = {3'd4, 5'b00000};
            "I": o_code = {3'd2, 5'b00000};
            "J": o_code = {3'd4, 5'b01110};
            "K": o_code = {3'd3, 5'b10100};
            "L": o_code = {3'd4, 5'b01000};
            "M": o_code = {3'd2, 5'b11000};
            "N": o_code = {3'd2, 5'b10000};
            "O": o_code = {3'd3, 5'b11100};
            "P": o_code = {3'd4, 5'b01100};
            "Q": o_code = {3'd4, 5'b11010};
            "R": o_code = {3'd3, 5'b01000};
            "S": o_code = {3'd3, 5'b00000};
            "T": o_code = {3'd1, 5'b10000};
            "U": o_code = {3'd3, 5'b00100};
            "V": o_code = {3'd4, 5'b00010};
            "W": o_code = {3'd3, 5'b01100};
            "X": o_code = {3'd4, 5'b10010};
            "Y": o_code = {3'd4, 5'b10110};
            "Z": o_code = {3'd4, 5'b11000};
            "0": o_code = {3'd5, 5'b11111};
            "1": o_code = {3'd5, 5'b01111};
            "2": o_code = {3'd5, 5'b00111};
            "3": o_code = {3'd5, 5'b00011};
            "4": o_code = {3'd5, 5'b00001};
            "5": o_code = {3'd5, 5'b00000};
            "6": o_code = {3'd5, 5'b10000};
            "7": o_code = {3'd5, 5'b11000};
            "8": o_code = {3'd5, 5'b11100};
            "9": o_code = {3'd5, 5'b11110};
            8'h20: o_is_space = 1'b1;
            default: o_is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_char_encoder.sv
// Accepts ASCII characters over valid/ready and keys them out as Morse
// marks and gaps on a single line, timed in units of UNIT_CYCLES clocks.
module morse_char_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 8
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_char,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_data_morse,
    output logic       o_busy,
    output logic       o_err
);

    morse_code_t w_code;
    logic        w_is_space;
    logic        w_is_valid;

    morse_state_t          r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CODE_LEN_W-1:0] r_idx;
    logic [CODE_LEN_W-1:0] r_len;
    logic [CODE_PAT_W-1:0] r_pat;

    morse_code_rom u_rom (
        .i_char     (i_char),
        .o_code     (w_code),
        .o_is_space (w_is_space),
        .o_is_valid (w_is_valid)
    );

    // Counter load for a phase lasting the given number of units.
    function automatic logic [CNT_W-1:0] f_load(input int unsigned units);
        return CNT_W'(units * UNIT_CYCLES - 1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_pat        <= '0;
            o_ready      <= 1'b1;
            o_data_morse <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        if (w_is_valid && !w_is_space) begin
                            r_state      <= MARK;
                            r_cnt        <= f_load(w_code.pat[CODE_PAT_W-1] ? DASH_U : DOT_U);
                            r_idx        <= '0;
                            r_len        <= w_code.len;
                            r_pat        <= w_code.pat;
                            o_ready      <= 1'b0;
                            o_busy       <= 1'b1;
                            o_data_morse <= 1'b1;
                        end else if (w_is_space) begin
                            r_state <= GAP_WORD;
                            r_cnt   <= f_load(WORD_EXTRA_U);
                            o_ready <= 1'b0;
                            o_busy  <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_idx + CODE_LEN_W'(1) == r_len) begin
                        r_state      <= CHAR_GAP;
                        r_cnt        <= f_load(CHAR_GAP_U);
                        o_data_morse <= 1'b0;
                    end else begin
                        r_state      <= ELEM_GAP;
                        r_cnt        <= f_load(ELEM_GAP_U);
                        r_idx        <= r_idx + CODE_LEN_W'(1);
                        r_pat        <= {r_pat[CODE_PAT_W-2:0], 1'b0};
                        o_data_morse <= 1'b0;
                    end
                end
                ELEM_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state      <= MARK;
                        r_cnt        <= f_load(r_pat[CODE_PAT_W-1] ? DASH_U : DOT_U);
                        o_data_morse <= 1'b1;
                    end
                end
                CHAR_GAP, GAP_WORD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    o_ready      <= 1'b1;
                    o_busy       <= 1'b0;
                    o_data_morse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_char_encoder.sv
// Bench for morse_char_encoder: two instances (1 and 2 clocks per unit) share
// stimulus; a waveform-queue model predicts every output on every cycle.
module tb_morse_char_encoder;

    typedef logic [2:0] samp_t;          // {line, busy, ready}
    typedef samp_t samp_q_t[$];
    localparam samp_t S_IDLE = 3'b001;
    localparam samp_t S_HIGH = 3'b110;
    localparam samp_t S_LOW  = 3'b010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_char = 8'h00;
    logic       i_valid = 1'b0;
    logic       d1, r1, b1, e1, d2, r2, b2, e2;

    int n_checks = 0;
    int n_errors = 0;

    samp_q_t m_q1, m_q2;
    samp_t   m_c1 = S_IDLE, m_c2 = S_IDLE;
    logic    m_e1 = 1'b0, m_e2 = 1'b0;

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits [10]  = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

    always #5 clk = ~clk;

    morse_char_encoder #(.UNIT_CYCLES(1), .CNT_W(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_char(i_char), .i_valid(i_valid),
        .o_ready(r1), .o_data_morse(d1), .o_busy(b1), .o_err(e1));

    morse_char_encoder #(.UNIT_CYCLES(2), .CNT_W(8)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_char(i_char), .i_valid(i_valid),
        .o_ready(r2), .o_data_morse(d2), .o_busy(b2), .o_err(e2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full per-cycle waveform of one character; empty means unsupported.
    function automatic samp_q_t build(input logic [7:0] c, input int u);
        samp_q_t    q;
        string      code;
        logic [7:0] up;
        q    = {};
        code = "";
        up   = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (up == 8'h20) begin
            for (int k = 0; k < 4 * u; k++) q.push_back(S_LOW);
            return q;
        end
        if (up >= 8'h41 && up <= 8'h5A) code = letters[up - 8'h41];
        else if (up >= 8'h30 && up <= 8'h39) code = digits[up - 8'h30];
        else return q;
        for (int e = 0; e < code.len(); e++) begin
            for (int k = 0; k < ((code[e] == "-") ? 3 : 1) * u; k++) q.push_back(S_HIGH);
            if (e != code.len() - 1)
                for (int k = 0; k < u; k++) q.push_back(S_LOW);
        end
        for (int k = 0; k < 3 * u; k++) q.push_back(S_LOW);
        return q;
    endfunction

    function automatic logic [63:0] line_bits(input samp_q_t q);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = {v[62:0], q[i][2]};
        return v;
    endfunction

    task automatic step(input int u, input samp_q_t qi, input samp_t ci,
                        output samp_q_t qo, output samp_t co, output logic eo);
        qo = qi;
        co = S_IDLE;
        eo = 1'b0;
        if (ci[0] && i_valid) begin
            qo = build(i_char, u);
            if (qo.size() == 0) eo = 1'b1;
        end
        if (qo.size() != 0) co = qo.pop_front();
    endtask

    // Advance both models at every edge and compare all outputs just after it.
    always begin
        @(posedge clk);
        if (rst) begin
            m_q1 = {};
            m_q2 = {};
            m_c1 = S_IDLE;
            m_c2 = S_IDLE;
            m_e1 = 1'b0;
            m_e2 = 1'b0;
        end else begin
            step(1, m_q1, m_c1, m_q1, m_c1, m_e1);
            step(2, m_q2, m_c2, m_q2, m_c2, m_e2);
        end
        #1;
        chk("u1_line",  64'(d1), 64'(m_c1[2]));
        chk("u1_busy",  64'(b1), 64'(m_c1[1]));
        chk("u1_ready", 64'(r1), 64'(m_c1[0]));
        chk("u1_err",   64'(e1), 64'(m_e1));
        chk("u2_line",  64'(d2), 64'(m_c2[2]));
        chk("u2_busy",  64'(b2), 64'(m_c2[1]));
        chk("u2_ready", 64'(r2), 64'(m_c2[0]));
        chk("u2_err",   64'(e2), 64'(m_e2));
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_c1[0] && m_c2[0]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [7:0] c);
        wait_idle();
        i_char  = c;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic trace(input int n, output logic [63:0] l1, output logic [63:0] rd1,
                         output logic [63:0] er1, output logic [63:0] l2, output logic [63:0] bz2);
        l1 = '0; rd1 = '0; er1 = '0; l2 = '0; bz2 = '0;
        for (int i = 0; i < n; i++) begin
            l1  = {l1[62:0], d1};
            rd1 = {rd1[62:0], r1};
            er1 = {er1[62:0], e1};
            l2  = {l2[62:0], d2};
            bz2 = {bz2[62:0], b2};
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      return 8'h41 + 8'($urandom_range(0, 25));
        else if (r < 6) return 8'h61 + 8'($urandom_range(0, 25));
        else if (r < 8) return 8'h30 + 8'($urandom_range(0, 9));
        else if (r == 8) return 8'h20;
        else            return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [63:0] l1, rd1, er1, l2, bz2, sos;
        samp_q_t     q;
        string       s;
        int          idx, xfers, tcnt;
        logic        pend;

        @(negedge clk);
        rst = 1'b0;
        chk("rst_line",  64'(d1), 64'd0);
        chk("rst_ready", 64'(r1), 64'd1);
        chk("rst_busy",  64'(b1), 64'd0);
        chk("rst_err",   64'(e1), 64'd0);

        chk("model_E",     line_bits(build(8'h45, 1)), 64'b1000);
        chk("model_a_u2",  line_bits(build(8'h61, 2)), 64'b1100111111000000);
        q = build(8'h23, 1);
        chk("model_hash",  64'(q.size()), 64'd0);
        q = build(8'h20, 1);
        chk("model_space", 64'(q.size()), 64'd4);

        send(8'h45);
        trace(5, l1, rd1, er1, l2, bz2);
        chk("E_line",  l1, 64'b10000);
        chk("E_ready", rd1, 64'b00001);

        send(8'h61);
        trace(20, l1, rd1, er1, l2, bz2);
        chk("a_u2_line", l2, 64'b11001111110000000000);
        chk("a_u2_busy", 64'($countones(bz2)), 64'd16);

        // SOS streamed with valid held high on the 1-clock instance.
        wait_idle();
        s = "SOS";
        idx = 0; xfers = 0; tcnt = 0; pend = 1'b0; sos = '0;
        i_char  = s[0];
        i_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (pend) begin
                idx++;
                xfers++;
                if (idx < 3) i_char = s[idx];
                else i_valid = 1'b0;
            end
            pend = i_valid && r1;
            if (xfers >= 1 && tcnt < 33) begin
                sos = {sos[62:0], d1};
                tcnt++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("sos_xfers", 64'(xfers), 64'd3);
        chk("sos_line",  sos, 64'(33'b101010000_111011101110000_101010000));

        send(8'h23);
        trace(5, l1, rd1, er1, l2, bz2);
        chk("hash_err",   er1, 64'b10000);
        chk("hash_ready", rd1, 64'b11111);
        chk("hash_line",  l1, 64'd0);
        send(8'h54);
        trace(6, l1, rd1, er1, l2, bz2);
        chk("T_line", l1, 64'b111000);

        // Asynchronous reset in the middle of a dash.
        send(8'h54);
        @(posedge clk);
        #3;
        chk("mid_pre_line", 64'(d1), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_line1",  64'(d1), 64'd0);
        chk("mid_ready1", 64'(r1), 64'd1);
        chk("mid_busy1",  64'(b1), 64'd0);
        chk("mid_line2",  64'(d2), 64'd0);
        chk("mid_ready2", 64'(r2), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'h45);
        trace(5, l1, rd1, er1, l2, bz2);
        chk("post_rst_E", l1, 64'b10000);

        for (int c = 0; c < 3000; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_char  = pick();
            @(negedge clk);
        end
        i_valid = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
